serial_pattern_detector: RTL and testbench
==========================================

# serial_pattern_detector

Parametrised serial bit-pattern detector that generalises our fixed-encoding Mealy sequence FSMs. It recognises a programmable LEN-bit pattern on a qualified serial input. It supports overlapping and non-overlapping matching, a combinational (Mealy) or registered (Moore-style) match output, and a saturating match counter. It sits between a serial bit source (debounced switch, deserialiser) and display/control logic that consumes match pulses and counts.

## Interface

- LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, LEN-bit pattern; PATTERN[LEN-1] is the first bit received.
- OVERLAP, 1, 1: a match's trailing bits can start the next match; 0: history restarts after each match.
- REG_OUT, 0, 0: out is combinational from the current input (Mealy); 1: out is registered, one cycle later.
- CNT_W, 8, width of match counter.

Ports:

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of history, fill and counter.
- in_valid  in  1  qualifies in for this cycle.
- in  in  1  serial data bit.
- out  out  1  match pulse.
- match_cnt  out  CNT_W  number of matches since reset/clear, saturating.
- state  out  SW  fill level; SW = $clog2(LEN).

## Operation

- Internal registers:
  - hist[LEN-2:0] holds the most recent accepted bits; the newest bit is in hist[0].
  - fill (0..LEN-1) counts valid history bits and saturates at LEN-1.
  - state = fill.
- match_now = in_valid && !clear && (fill == LEN-1) && ({hist, in} == PATTERN).
- On an accepted beat (in_valid && !clear):
  - hist shifts left, in enters at bit 0. For LEN=2, hist is the single last bit.
  - fill <= min(fill+1, LEN-1).
  - If match_now && OVERLAP==0: fill <= 0. hist still shifts but is don't-care.
- When in_valid=0: hist, fill and match_cnt hold. out=0 in Mealy mode.
- match_cnt increments by 1 on match_now and holds at all-ones (2^CNT_W-1).
- clear has priority over in_valid:
  - next edge sets hist=0, fill=0, match_cnt=0 and registered out=0.
  - match_now is suppressed during clear.
- REG_OUT=0: out = match_now, combinational from in/in_valid.
- REG_OUT=1: out_q <= match_now each edge; out = out_q; single-cycle pulse per match.
- Matching is bit-exact; there is no wildcard support.

## Timing

- Reset (rst_n low, asynchronous, effective without a clock edge): hist=0, fill=0, state=0, match_cnt=0, out_q=0, so out=0 in both modes. Registers release on the first rising edge after rst_n rises.
- Reset mid-pattern discards all partial history. A full LEN accepted bits are needed after release before the next match.
- Mealy latency: out is high in the same cycle as the final pattern bit (in_valid high). match_cnt updates at that cycle's closing edge.
- Registered latency: out is high for exactly the one cycle after the final bit's edge. match_cnt updates at the same edge that raises out.
- Back-to-back matches (OVERLAP=1, periodic pattern) produce consecutive out pulses with no dead cycle.
- A clear concurrent with the final pattern bit: no match, no count.
- Counter at saturation with another match: out still pulses, and match_cnt stays all-ones.

## Test plan

Defaults: LEN=4, PATTERN=1011, OVERLAP=1, REG_OUT=0, CNT_W=8 unless noted.

- **Reset:** hold rst_n=0 with in toggling → out=0, match_cnt=0, state=0; assert rst_n low between edges → outputs clear immediately.
- **Basic match:** accepted bits 1,0,1,1 on consecutive cycles → state 1,2,3,3; out=1 only during the 4th-bit cycle; match_cnt=1 after that edge.
- **Overlap:** bits 1,0,1,1,0,1,1 with OVERLAP=1 → out on bits 4 and 7, match_cnt=2; same stream with OVERLAP=0 → out only on bit 4, match_cnt=1, state=3 at end.
- **Gaps and mode:** bits 1,0,(in_valid=0 for 3 cycles, in=1),1,1 → no out during the gap, state held at 2, match on the 4th accepted bit; repeat with REG_OUT=1 → out one cycle after the 4th bit, width exactly 1.
- **Saturation:** CNT_W=2, 5 non-overlapping 1011 sequences → match_cnt 1,2,3,3,3; out pulses 5 times.
- **Clear and reset mid-operation:**
  - Bits 1,0,1 then rst_n low for one cycle, then 1 → no match, state=1.
  - 1,0,1 then final 1 with clear=1 → out=0, match_cnt=0, state=0.

Source files
------------

// File: rtl/serial_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_detector
// Brief    : Programmable LEN-bit serial pattern detector with overlap and
//            Mealy/registered match output, plus saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_detector #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             REG_OUT = 0,
    parameter int             CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic                    in,
    output logic                    out,
    output logic [CNT_W-1:0]        match_cnt,
    output logic [$clog2(LEN)-1:0]  state
);

    localparam int                 c_SW       = $clog2(LEN);
    localparam logic [c_SW-1:0]    c_FILL_MAX = c_SW'(LEN - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

    logic [LEN-2:0]   r_hist;
    logic [c_SW-1:0]  r_fill;
    logic [CNT_W-1:0] r_cnt;

    logic [LEN-2:0]   w_hist_next;
    logic [c_SW-1:0]  w_fill_next;
    logic             w_accept;
    logic             w_match;

    assign w_accept = in_valid && !clear;
    assign w_match  = w_accept && (r_fill == c_FILL_MAX) && ({r_hist, in} == PATTERN);

    generate
        if (LEN > 2) begin : g_hist_shift
            assign w_hist_next = {r_hist[LEN-3:0], in};
        end else begin : g_hist_single
            assign w_hist_next = in;
        end
    endgenerate

    // Non-overlapping mode forgets everything after a hit; history bits
    // become irrelevant because fill gates the next compare.
    always_comb begin
        w_fill_next = r_fill;
        if (w_match && (OVERLAP == 0)) begin
            w_fill_next = '0;
        end else if (r_fill != c_FILL_MAX) begin
            w_fill_next = r_fill + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
        end else begin
            if (in_valid) begin
                r_hist <= w_hist_next;
                r_fill <= w_fill_next;
            end
            if (w_match && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    generate
        if (REG_OUT != 0) begin : g_out_reg
            logic r_out_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_q <= 1'b0;
                end else if (clear) begin
                    r_out_q <= 1'b0;
                end else begin
                    r_out_q <= w_match;
                end
            end
            assign out = r_out_q;
        end else begin : g_out_comb
            assign out = w_match;
        end
    endgenerate

    assign match_cnt = r_cnt;
    assign state     = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_detector
// Brief    : Directed self-checking bench; four detector variants share one
//            input stream (default, non-overlap, registered, 2-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_detector;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_bit;

    logic       out0, out1, out2, out3;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;
    logic [1:0] st0, st1, st2, st3;

    int checks   = 0;
    int failures = 0;

    serial_pattern_detector u_def (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in(in_bit),
        .out(out0), .match_cnt(cnt0), .state(st0));

    serial_pattern_detector #(.OVERLAP(0)) u_novl (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in(in_bit),
        .out(out1), .match_cnt(cnt1), .state(st1));

    serial_pattern_detector #(.REG_OUT(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in(in_bit),
        .out(out2), .match_cnt(cnt2), .state(st2));

    serial_pattern_detector #(.OVERLAP(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in(in_bit),
        .out(out3), .match_cnt(cnt3), .state(st3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: drive, check Mealy outputs mid-cycle, then check the
    // registered output just after the closing edge.
    task automatic beat(input logic v, input logic b, input logic c,
                        input logic e0, input logic e1, input logic e3);
        in_valid = v;
        in_bit   = b;
        clear    = c;
        @(negedge clk);
        check_val("out_def", 32'(out0), 32'(e0));
        check_val("out_novl", 32'(out1), 32'(e1));
        check_val("out_sat", 32'(out3), 32'(e3));
        @(posedge clk);
        #1;
        check_val("out_reg", 32'(out2), 32'(e0));
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        logic [6:0] bits7;
        logic [6:0] m_def;
        logic [6:0] m_novl;
        logic [3:0] pat;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0;

        // reset held with live input
        beat(1, 1, 0, 0, 0, 0);
        beat(1, 0, 0, 0, 0, 0);
        beat(1, 1, 0, 0, 0, 0);
        check_val("rst_cnt", 32'(cnt0), 0);
        check_val("rst_state", 32'(st0), 0);
        check_val("rst_cnt_reg", 32'(cnt2), 0);
        rst_n = 1'b1;

        // basic match
        beat(1, 1, 0, 0, 0, 0); check_val("basic_st1", 32'(st0), 1);
        beat(1, 0, 0, 0, 0, 0); check_val("basic_st2", 32'(st0), 2);
        beat(1, 1, 0, 0, 0, 0); check_val("basic_st3", 32'(st0), 3);
        beat(1, 1, 0, 1, 1, 1); check_val("basic_st4", 32'(st0), 3);
        check_val("basic_st_novl", 32'(st1), 0);
        check_val("basic_cnt", 32'(cnt0), 1);
        check_val("basic_cnt_reg", 32'(cnt2), 1);
        beat(0, 0, 1, 0, 0, 0);
        check_val("clr_cnt", 32'(cnt0), 0);
        check_val("clr_state", 32'(st0), 0);

        // overlap vs non-overlap on 1011011
        bits7  = 7'b1011011;
        m_def  = 7'b0001001;
        m_novl = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            beat(1, bits7[i], 0, m_def[i], m_novl[i], m_novl[i]);
        end
        check_val("ovl_cnt", 32'(cnt0), 2);
        check_val("novl_cnt", 32'(cnt1), 1);
        check_val("novl_state", 32'(st1), 3);
        check_val("ovl_cnt_reg", 32'(cnt2), 2);
        check_val("novl_cnt_sat", 32'(cnt3), 1);
        beat(0, 0, 1, 0, 0, 0);

        // gap of three unqualified cycles mid-pattern
        beat(1, 1, 0, 0, 0, 0);
        beat(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            beat(0, 1, 0, 0, 0, 0);
            check_val("gap_state", 32'(st0), 2);
        end
        beat(1, 1, 0, 0, 0, 0);
        beat(1, 1, 0, 1, 1, 1);
        check_val("gap_cnt", 32'(cnt0), 1);
        check_val("gap_cnt_reg", 32'(cnt2), 1);
        beat(0, 0, 0, 0, 0, 0);
        beat(0, 0, 1, 0, 0, 0);

        // counter saturation, five back-to-back 1011 sequences
        pat = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            for (int j = 3; j >= 0; j--) begin
                beat(1, pat[j], 0, j == 0, j == 0, j == 0);
            end
            check_val("sat_cnt", 32'(cnt3), (k < 3) ? k + 1 : 3);
        end
        check_val("sat_cnt_def", 32'(cnt0), 5);
        check_val("sat_cnt_novl", 32'(cnt1), 5);

        // asynchronous reset mid-pattern
        beat(1, 1, 0, 0, 0, 0);
        beat(1, 0, 0, 0, 0, 0);
        beat(1, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_val("arst_cnt", 32'(cnt0), 0);
        check_val("arst_state", 32'(st0), 0);
        check_val("arst_cnt_sat", 32'(cnt3), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(1, 1, 0, 0, 0, 0);
        check_val("arst_resume_st", 32'(st0), 1);
        check_val("arst_resume_cnt", 32'(cnt0), 0);

        // clear concurrent with final pattern bit
        beat(1, 0, 0, 0, 0, 0);
        beat(1, 1, 0, 0, 0, 0);
        check_val("clrfin_pre_st", 32'(st0), 3);
        beat(1, 1, 1, 0, 0, 0);
        check_val("clrfin_cnt", 32'(cnt0), 0);
        check_val("clrfin_state", 32'(st0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
